instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/cpu_pkg.sv | 18 +
 rtl/instruction_fetch.sv | 115 +++++++++++
 tb/tb_instruction_fetch.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage.
//   DEF_ADDR_W / DEF_DATA_W : default instruction RAM address / word widths
//   HALT_OPCODE             : top nibble that marks a halt instruction
//   fetch_state_t           : fetch FSM state encoding
// Optional feature macro: HALT_DETECT_EN adds the HALTED state.
package cpu_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 16;
  localparam logic [3:0] HALT_OPCODE = 4'hF;

`ifdef HALT_DETECT_EN
  typedef enum logic [2:0] {IDLE, READ, WAIT, HOLD, HALTED} fetch_state_t;
`else
  typedef enum logic [1:0] {IDLE, READ, WAIT, HOLD} fetch_state_t;
`endif

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: latches the PC address on start, reads one word
// from the external instruction RAM (one-cycle read latency), presents it in
// ir with a valid/ready handshake and pulses done after the decoder accepts.
//   clk, rst_n          : clock, asynchronous active-low reset
//   pc_addr, start      : fetch address and request (sampled in IDLE or on
//                         the accepting cycle for back-to-back fetches)
//   ram_addr, ram_rd_en : RAM read address / strobe
//   ram_rdata           : RAM data, valid the cycle after ram_rd_en
//   ir, ir_valid, ir_ready : instruction register handshake
//   done                : one-cycle pulse after each accepted instruction
//   busy                : a fetch is in flight (not IDLE / HALTED)
// Optional feature macro: HALT_DETECT_EN -- accepting an instruction whose top
// nibble is HALT_OPCODE parks the block in HALTED until reset.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic              done,
  output logic              busy
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] ir_q;
  logic              done_q, done_nxt;
  logic              latch_addr;
  logic              xfer;
  logic              halt_op;

  assign xfer = (state == HOLD) && ir_ready;

`ifdef HALT_DETECT_EN
  assign halt_op = (ir_q[DATA_W-1 -: 4] == HALT_OPCODE);
`else
  assign halt_op = 1'b0;
`endif

  always_comb begin
    state_nxt  = state;
    latch_addr = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt  = READ;
        latch_addr = 1'b1;
      end
      READ: state_nxt = WAIT;
      WAIT: state_nxt = HOLD;
      HOLD: if (ir_ready) begin
`ifdef HALT_DETECT_EN
        if (halt_op) begin
          // Halt swallows the done pulse so the PC never advances past it.
          state_nxt = HALTED;
        end else
`endif
        begin
          done_nxt = 1'b1;
          // Back-to-back: a start on the accepting cycle skips IDLE.
          if (start) begin
            state_nxt  = READ;
            latch_addr = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
`ifdef HALT_DETECT_EN
      HALTED: state_nxt = HALTED;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      ir_q   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
      if (latch_addr) addr_q <= pc_addr;
      if (state == WAIT) ir_q <= ram_rdata;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_rd_en = (state == READ);
  assign ir        = ir_q;
  assign ir_valid  = (state == HOLD);
  assign done      = done_q;
`ifdef HALT_DETECT_EN
  assign busy      = (state != IDLE) && (state != HALTED);
`else
  assign busy      = (state != IDLE);
`endif

  // xfer / halt_op kept as named terms for readability in waveforms.
  logic unused_ok;
  assign unused_ok = xfer ^ halt_op;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: the driver pushes expected read
// addresses and instruction words when a fetch is requested; a negedge
// monitor pops and compares on every RAM read and every ir handshake.
module tb_instruction_fetch;

  logic        clk, rst_n, start, ram_rd_en, ir_valid, ir_ready, done, busy;
  logic [5:0]  pc_addr, ram_addr;
  logic [15:0] ram_rdata, ir;
  logic [15:0] mem [64];

  logic [5:0]  q_addr[$];
  logic [15:0] q_data[$];
  int checks = 0, errors = 0, done_cnt = 0;
  logic        done_exp = 0;
  logic [15:0] last_ir = '0;

  instruction_fetch dut (
    .clk(clk), .rst_n(rst_n), .pc_addr(pc_addr), .start(start),
    .ram_addr(ram_addr), .ram_rd_en(ram_rd_en), .ram_rdata(ram_rdata),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready), .done(done), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // External RAM: one-cycle read latency.
  always @(posedge clk) if (ram_rd_en) ram_rdata <= mem[ram_addr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_ir"}, ir, 0);
    check({tag, "_ir_valid"}, ir_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ram_rd_en"}, ram_rd_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Issue a fetch from IDLE, stall `stall` cycles, then randomly accept.
  task automatic fetch(input logic [5:0] a, input int stall);
    int n;
    pc_addr = a; start = 1;
    q_addr.push_back(a); q_data.push_back(mem[a]);
    tick();
    start = 0; pc_addr = 6'($urandom);
    n = 0;
    while (busy && n < 60) begin
      ir_ready = (n >= stall) ? 1'($urandom_range(0, 1)) | (n > stall + 4) : 1'b0;
      tick();
      n++;
    end
    ir_ready = 0;
    check("fetch_timeout", busy, 0);
  endtask

  task automatic pulse_reset();
    rst_n = 0; #1;
    q_addr.delete(); q_data.delete();
    outputs_zero("reset");
    tick(); tick();
    rst_n = 1;
  endtask

  // Monitor / scoreboard.
  always begin
    @(negedge clk);
    if (!rst_n) begin
      done_exp = 0;
      last_ir  = '0;
    end else begin
      check("done", done, done_exp);
      if (done) done_cnt++;
      done_exp = 0;
      if (ram_rd_en) begin
        check("read_expected", q_addr.size() != 0, 1);
        if (q_addr.size() != 0) check("ram_addr", ram_addr, q_addr.pop_front());
      end
      if (ir_valid) begin
        check("ir_expected", q_data.size() != 0, 1);
        if (q_data.size() != 0) begin
          check("ir", ir, q_data[0]);
          if (ir_ready) begin
            last_ir  = q_data.pop_front();
            done_exp = 1;
`ifdef HALT_DETECT_EN
            if (last_ir[15:12] == 4'hF) done_exp = 0;
`endif
          end
        end
      end else begin
        check("ir_hold", ir, last_ir);
      end
    end
  end

  initial begin
    int d0;
    rst_n = 0; start = 0; ir_ready = 0; pc_addr = 0;
    foreach (mem[i]) mem[i] = 16'($urandom_range(0, 16'hEFFF));
    mem[5] = 16'h1234; mem[9] = 16'hABCD;
    #1 outputs_zero("init");
    tick(); tick();
    rst_n = 1;
    tick();

    // Basic fetch with latency checks and a 10-cycle stall.
    pc_addr = 5; start = 1;
    q_addr.push_back(5); q_data.push_back(16'h1234);
    tick();
    start = 0;
    check("n1_rd_en", ram_rd_en, 1);
    check("n1_addr", ram_addr, 5);
    check("n1_busy", busy, 1);
    tick();
    check("n2_ir_valid", ir_valid, 0);
    tick();
    check("n3_ir_valid", ir_valid, 1);
    check("n3_ir", ir, 16'h1234);
    repeat (10) tick();
    check("stall_ir_valid", ir_valid, 1);
    check("stall_ir", ir, 16'h1234);
    ir_ready = 1;
    tick();
    ir_ready = 0;
    check("basic_done", done, 1);
    check("basic_idle", busy, 0);
    tick();
    check("done_one_cycle", done, 0);

    // Ignored pc_addr/start during WAIT.
    pc_addr = 5; start = 1;
    q_addr.push_back(5); q_data.push_back(16'h1234);
    tick();
    start = 0;
    tick();
    pc_addr = 9; start = 1;
    tick();
    start = 0; ir_ready = 1;
    tick();
    ir_ready = 0;
    repeat (3) tick();
    check("ignore_idle", busy, 0);

    // Back-to-back: start held; PC advanced in the accepting cycle.
    d0 = done_cnt;
    pc_addr = 0; start = 1;
    q_addr.push_back(0); q_data.push_back(mem[0]);
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      while (!ir_valid && n < 20) begin tick(); n++; end
      check("b2b_valid", ir_valid, 1);
      ir_ready = 1;
      if (i < 3) begin
        pc_addr = 6'(i + 1);
        q_addr.push_back(6'(i + 1)); q_data.push_back(mem[i + 1]);
      end else start = 0;
      tick();
      ir_ready = 0;
      if (i < 3) check("b2b_no_idle", busy, 1);
    end
    tick(); tick();
    check("b2b_done_count", done_cnt - d0, 4);

    // Reset while in WAIT.
    fetch(6'd7, 0);
    pc_addr = 8; start = 1;
    q_addr.push_back(8); q_data.push_back(mem[8]);
    tick(); start = 0;
    tick();
    pulse_reset();
    tick();
    fetch(6'd8, 1);

    // Randomized fetches, including the top address.
    for (int k = 0; k < 25; k++) begin
      fetch((k % 8 == 3) ? 6'd63 : 6'($urandom_range(0, 63)), $urandom_range(0, 4));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Halt opcode.
    mem[2] = 16'hF000;
    fetch(6'd2, 0);
    tick();
`ifdef HALT_DETECT_EN
    check("halt_busy", busy, 0);
    pc_addr = 3; start = 1;
    repeat (4) tick();
    start = 0;
    check("halt_ignore_busy", busy, 0);
    check("halt_ignore_valid", ir_valid, 0);
    pulse_reset();
    tick();
`endif
    fetch(6'd3, 1);
    repeat (3) tick();
    check("queues_empty", q_addr.size() + q_data.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
